// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the 5-stage MIPS pipeline hazard/forwarding logic.
//   - ADDR_W               : default register address width
//   - FWD_NONE/MEM/WB      : 2-bit EX operand-mux selects
//                            (regfile / EX-MEM result / MEM-WB result)
//   - STALL_CNT_W          : width of the load-use stall down-counter
//                            (enough for LOAD_STALL up to 7)
//   - hz_state_t           : hazard controller FSM states
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int ADDR_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM  = 2'b01;  // operand from EX/MEM (EX producer)
  localparam logic [1:0] FWD_WB   = 2'b10;  // operand from MEM/WB (MEM producer)

  localparam int STALL_CNT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage : pipeline_pkg

// File: rtl/hazard_forward_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Forwarding-source selection for one ID source operand. Purely
//   combinational.
//
// Ports
//   src_adr_i       in  ADDR_W  source register address of the ID instruction
//   src_used_i      in  1       ID instruction actually reads this operand
//   ex_wadr_i       in  ADDR_W  destination register of the EX instruction
//   ex_regwrite_i   in  1       EX instruction writes the register file
//   mem_wadr_i      in  ADDR_W  destination register of the MEM instruction
//   mem_regwrite_i  in  1       MEM instruction writes the register file
//   sel_o           out 2       FWD_MEM / FWD_WB / FWD_NONE
//   m_ex_o          out 1       operand depends on the EX instruction
// -----------------------------------------------------------------------------
module fwd_select #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_adr_i,
  input  logic              src_used_i,
  input  logic [ADDR_W-1:0] ex_wadr_i,
  input  logic              ex_regwrite_i,
  input  logic [ADDR_W-1:0] mem_wadr_i,
  input  logic              mem_regwrite_i,
  output logic [1:0]        sel_o,
  output logic              m_ex_o
);
  import pipeline_pkg::*;

  logic src_live;
  logic m_mem;

  // $0 is hard-wired zero, so a write to it can never create a dependency.
  assign src_live = src_used_i && (src_adr_i != '0);

  assign m_ex_o = src_live && ex_regwrite_i  && (ex_wadr_i  == src_adr_i);
  assign m_mem  = src_live && mem_regwrite_i && (mem_wadr_i == src_adr_i);

  // The EX producer is younger than the MEM producer, so its value wins.
  assign sel_o = m_ex_o ? FWD_MEM :
                 m_mem  ? FWD_WB  : FWD_NONE;

endmodule : fwd_select

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//   Hazard and forwarding controller between ID and EX of the 5-stage MIPS
//   pipeline with BTB. Detects RAW hazards on both ID source operands,
//   registers forward-mux selects into ID/EX, inserts LOAD_STALL-cycle
//   load-use stalls and turns BTB mispredict redirects into a flush.
//
// Parameters
//   ADDR_W      register address width
//   LOAD_STALL  load-use stall length in cycles (1..7)
//   CNT_W       statistics counter width (only with HAZARD_STATS_EN)
//
// Ports
//   CLK           in   1       pipeline clock, rising edge
//   CLR           in   1       synchronous active-high reset
//   ID_R1Adr      in   ADDR_W  rs of the ID instruction
//   ID_R2Adr      in   ADDR_W  rt of the ID instruction
//   ID_R1Used     in   1       ID instruction reads rs
//   ID_R2Used     in   1       ID instruction reads rt
//   EX_WAdr       in   ADDR_W  destination of the EX instruction
//   EX_RegWrite   in   1       EX instruction writes the register file
//   EX_MemRead    in   1       EX instruction is a load
//   MEM_WAdr      in   ADDR_W  destination of the MEM instruction
//   MEM_RegWrite  in   1       MEM instruction writes the register file
//   Redirect      in   1       EX branch outcome disagrees with the BTB
//   Stall_PC_ID   out  1       hold PC and IF/ID
//   Bubble_ID_EX  out  1       load a NOP into ID/EX
//   Flush_IF_ID   out  1       clear IF/ID
//   R1_Fwd        out  2       registered EX select for rs
//   R2_Fwd        out  2       registered EX select for rt
//   Stall_Cnt     out  CNT_W   saturating stall-cycle count (HAZARD_STATS_EN)
//   Flush_Cnt     out  CNT_W   saturating redirect count    (HAZARD_STATS_EN)
//
// Configuration
//   HAZARD_STATS_EN : when defined, adds CNT_W and the Stall_Cnt/Flush_Cnt
//                     statistics counters; when undefined they do not exist.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int ADDR_W     = pipeline_pkg::ADDR_W,
  parameter int LOAD_STALL = 1
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] ID_R1Adr,
  input  logic [ADDR_W-1:0] ID_R2Adr,
  input  logic              ID_R1Used,
  input  logic              ID_R2Used,
  input  logic [ADDR_W-1:0] EX_WAdr,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic [ADDR_W-1:0] MEM_WAdr,
  input  logic              MEM_RegWrite,
  input  logic              Redirect,
  output logic              Stall_PC_ID,
  output logic              Bubble_ID_EX,
  output logic              Flush_IF_ID,
  output logic [1:0]        R1_Fwd,
  output logic [1:0]        R2_Fwd
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt
`endif
);
  import pipeline_pkg::*;

  localparam logic [STALL_CNT_W-1:0] LOAD_CNT = STALL_CNT_W'(LOAD_STALL - 1);

  // ---------------------------------------------------------------------------
  // Per-operand hazard detection
  // ---------------------------------------------------------------------------
  logic [1:0] sel_1, sel_2;
  logic       m_ex_1, m_ex_2;

  fwd_select #(.ADDR_W(ADDR_W)) u_fwd_r1 (
    .src_adr_i      (ID_R1Adr),
    .src_used_i     (ID_R1Used),
    .ex_wadr_i      (EX_WAdr),
    .ex_regwrite_i  (EX_RegWrite),
    .mem_wadr_i     (MEM_WAdr),
    .mem_regwrite_i (MEM_RegWrite),
    .sel_o          (sel_1),
    .m_ex_o         (m_ex_1)
  );

  fwd_select #(.ADDR_W(ADDR_W)) u_fwd_r2 (
    .src_adr_i      (ID_R2Adr),
    .src_used_i     (ID_R2Used),
    .ex_wadr_i      (EX_WAdr),
    .ex_regwrite_i  (EX_RegWrite),
    .mem_wadr_i     (MEM_WAdr),
    .mem_regwrite_i (MEM_RegWrite),
    .sel_o          (sel_2),
    .m_ex_o         (m_ex_2)
  );

  logic load_use;
  assign load_use = EX_MemRead && (m_ex_1 || m_ex_2);

  // ---------------------------------------------------------------------------
  // Load-use stall FSM
  // ---------------------------------------------------------------------------
  hz_state_t                state_q, state_d;
  logic [STALL_CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]               r1_fwd_q, r2_fwd_q;
  logic                     stall_active;

  // The load-use cycle itself is the first stall cycle, so STALL only has to
  // cover the remaining LOAD_STALL-1 cycles: it holds the pipeline while cnt
  // is non-zero, and its cnt==0 cycle is the exit cycle that no longer stalls.
  assign stall_active = (state_q == STALL) && (cnt_q != '0);

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    Stall_PC_ID  = 1'b0;
    Bubble_ID_EX = 1'b0;
    Flush_IF_ID  = 1'b0;
    if (!CLR) begin
      Stall_PC_ID  = !Redirect && (load_use || stall_active);
      Bubble_ID_EX = Stall_PC_ID || Redirect;
      Flush_IF_ID  = Redirect;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Redirect) begin
      // A mispredict squashes the stalled instruction, so the stall is moot.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (stall_active) begin
      cnt_d   = cnt_q - STALL_CNT_W'(1);
    end else if (load_use) begin
      state_d = STALL;
      cnt_d   = LOAD_CNT;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r1_fwd_q <= FWD_NONE;
      r2_fwd_q <= FWD_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // A bubble entering EX must never forward anything.
      r1_fwd_q <= Bubble_ID_EX ? FWD_NONE : sel_1;
      r2_fwd_q <= Bubble_ID_EX ? FWD_NONE : sel_2;
    end
  end

  assign R1_Fwd = r1_fwd_q;
  assign R2_Fwd = r2_fwd_q;

  // ---------------------------------------------------------------------------
  // Optional statistics counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_PC_ID && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (Redirect    && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`endif

endmodule : hazard_forward_unit
